vga_frame_writer: RTL
=====================

Name: vga_frame_writer

Overview:
- Downstream consumer of a pixel-plot stream: (x, y, 24-bit colour, plot) from a drawing/demo block.
- Buffers accepted pixels in a small FIFO, converts each colour to 12-bit, and translates (x,y) to a linear address.
- Writes each pixel into the write port of the 12-bit video memory.
- Clears the frame to a background colour after reset and on request.

Parameters:
- nX, 9, x coordinate width
- nY, 8, y coordinate width
- COLS, 320, visible columns
- ROWS, 240, visible rows
- Mn, 17, video memory address width
- BG_COLOR, 12'h000, background colour written during a clear
- DEPTH, 4, pixel FIFO depth (power of 2, >=2)

Ports:
- CLOCK_50 in 1: 50 MHz clock, all state on rising edge
- Resetn in 1: synchronous, active-low reset
- in_x in nX: pixel column
- in_y in nY: pixel row
- in_color in 24: pixel colour {R8,G8,B8}
- in_plot in 1: pixel valid
- in_ready out 1: FIFO can accept; a pixel is accepted when in_plot && in_ready
- clear_req in 1: one-cycle pulse requesting a frame clear
- mem_addr out Mn: video memory write address (registered)
- mem_data out 12: video memory write data (registered)
- mem_we out 1: write enable (registered)
- clearing out 1: high while the CLEAR sweep is active
- oob_count out 16: saturating count of accepted out-of-range pixels

Behaviour:
- Decided: reset Resetn, synchronous, active-low; clock CLOCK_50.
- Reset values: mem_we=0, mem_addr=0, mem_data=0, oob_count=0, FIFO empty; state=CLEAR with clear address 0, so clearing=1 on the first cycle after reset.
- in_ready = (FIFO count < DEPTH), combinational from the count only. It is independent of state.
- Colour conversion: {in_color[23:20], in_color[15:12], in_color[7:4]}.
- Address: y*COLS + x, computed at Mn+1 bits, truncated to Mn.
- Range check at input: x>=COLS or y>=ROWS means the pixel is accepted but not enqueued.
  - oob_count increments by 1, saturating at 16'hFFFF.
- FSM CLEAR:
  - Each cycle: mem_we=1, mem_addr=clr_addr, mem_data=BG_COLOR; clr_addr increments.
  - After the write of address COLS*ROWS-1, go to RUN. Total: exactly COLS*ROWS consecutive writes.
  - The FIFO keeps accepting until full; it is not popped during CLEAR.
- FSM RUN:
  - If the FIFO is non-empty, pop one entry per cycle; the registered outputs present it the next cycle with mem_we=1. Otherwise mem_we=0.
  - Latency: with an empty FIFO, a pixel accepted in cycle t appears with mem_we=1 in cycle t+2.
  - Back-to-back pixels give one write per cycle, in acceptance order.
- clear_req=1 in any state:
  - FIFO is flushed, including any pixel accepted in the same cycle.
  - clr_addr is set to 0 and the state goes to CLEAR; the first BG write occurs next cycle.
  - clear_req during CLEAR restarts the sweep from address 0.
- Simultaneous push and pop when the FIFO is full: the push is not possible (in_ready=0).
  - When non-full, push and pop in the same cycle leave the count unchanged.
- Reset mid-operation (any state) returns to the reset values above; the FIFO content is lost.
- The FIFO pointers wrap modulo DEPTH; count is DEPTH-width+1 bits.
- mem_we is never high for an out-of-range pixel.

Test Plan:
- Use COLS=8, ROWS=4, Mn=5 for all scenarios.
- Reset clear: Resetn low 2 cycles then high -> 32 consecutive cycles with mem_we=1, mem_addr 0..31, mem_data=12'h000, clearing=1; then clearing=0 and mem_we=0.
- Single pixel after clear: x=3, y=2, colour 24'hFF8040 accepted at cycle t -> cycle t+2: mem_we=1, mem_addr=19, mem_data=12'hF84; mem_we=0 at t+3.
- Backpressure during clear: present 5 valid pixels on successive cycles during CLEAR -> in_ready=0 after the 4th is accepted. The first 4 are written in order starting the cycle after the last BG write; the 5th is accepted once in_ready=1.
- Out-of-range: x=8, y=0 and x=0, y=4 -> no mem_we for either, oob_count=2. Preload oob_count near saturation by forcing 70000 OOB pixels -> oob_count holds at 16'hFFFF.
- clear_req mid-stream: 3 pixels queued, clear_req pulse -> none of the 3 is written; 32 BG writes from address 0 follow. A clear_req during CLEAR at address 10 restarts at address 0.
- Reset mid-clear: Resetn low at clear address 17 -> mem_we=0 during reset, then a full sweep starting from address 0.

Source files
------------

// File: rtl/vga_frame_writer_if.sv
// Pixel-plot stream into the frame writer:
// coordinates, 24-bit colour, valid/ready.
interface vga_frame_writer_if #(
  parameter int nX = 9,
  parameter int nY = 8
);
  logic [nX-1:0] x;
  logic [nY-1:0] y;
  logic [23:0]   color;
  logic          plot;
  logic          ready;

  modport master (
    output x, y, color, plot,
    input  ready
  );
  modport slave (
    input  x, y, color, plot,
    output ready
  );
endinterface

// File: rtl/vga_frame_writer.sv
// Buffers plotted pixels and writes them into 12-bit video memory,
// sweeping the frame to a background colour after reset or on request.
module vga_frame_writer #(
  parameter int          nX       = 9,
  parameter int          nY       = 8,
  parameter int          COLS     = 320,
  parameter int          ROWS     = 240,
  parameter int          Mn       = 17,
  parameter logic [11:0] BG_COLOR = 12'h000,
  parameter int          DEPTH    = 4
) (
  input  logic              CLOCK_50,
  input  logic              Resetn,
  vga_frame_writer_if.slave pix,
  input  logic              clear_req,
  output logic [Mn-1:0]     mem_addr,
  output logic [11:0]       mem_data,
  output logic              mem_we,
  output logic              clearing,
  output logic [15:0]       oob_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [Mn-1:0] LAST = Mn'(COLS * ROWS - 1);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t        state, state_n;
  logic [Mn-1:0] clr_addr, clr_addr_n;
  logic [Mn-1:0] addr_n;
  logic [11:0]   data_n;
  logic          we_n, bg_n, bg_q;

  logic [Mn-1:0] fifo_addr [DEPTH];
  logic [11:0]   fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;

  logic          accept, in_range, push, pop;
  logic [Mn-1:0] lin;
  logic [11:0]   color12;
  logic          unused_bits;

  assign pix.ready = count < (PW + 1)'(DEPTH);
  assign accept    = pix.plot && pix.ready;
  assign in_range  = (32'(pix.x) < COLS) && (32'(pix.y) < ROWS);
  assign lin       = Mn'(32'(pix.y) * COLS + 32'(pix.x));
  assign color12   = {pix.color[23:20], pix.color[15:12], pix.color[7:4]};
  assign unused_bits = ^{pix.color[19:16], pix.color[11:8], pix.color[3:0]};

  // A pixel arriving alongside clear_req is flushed with the rest.
  assign push = accept && in_range && !clear_req;
  assign pop  = (state == RUN) && (count != '0) && !clear_req;

  assign clearing = (state == CLEAR) || bg_q;

  always_comb begin
    state_n    = state;
    clr_addr_n = clr_addr;
    we_n       = 1'b0;
    bg_n       = 1'b0;
    addr_n     = mem_addr;
    data_n     = mem_data;
    if (clear_req) begin
      state_n    = CLEAR;
      clr_addr_n = '0;
    end else begin
      unique case (state)
        CLEAR: begin
          we_n       = 1'b1;
          bg_n       = 1'b1;
          addr_n     = clr_addr;
          data_n     = BG_COLOR;
          clr_addr_n = clr_addr + 1'b1;
          if (clr_addr == LAST) state_n = RUN;
        end
        RUN: begin
          if (pop) begin
            we_n   = 1'b1;
            addr_n = fifo_addr[rd_ptr];
            data_n = fifo_data[rd_ptr];
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state    <= CLEAR;
      clr_addr <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      bg_q     <= 1'b0;
    end else begin
      state    <= state_n;
      clr_addr <= clr_addr_n;
      mem_we   <= we_n;
      mem_addr <= addr_n;
      mem_data <= data_n;
      bg_q     <= bg_n;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn || clear_req) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      fifo_addr[wr_ptr] <= lin;
      fifo_data[wr_ptr] <= color12;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn)
      oob_count <= '0;
    else if (accept && !in_range && oob_count != 16'hFFFF)
      oob_count <= oob_count + 16'd1;
  end
endmodule
